// File: rtl/inst_prefetch.sv
// Instruction prefetch: sequential fetch with bounded outstanding reads, a PC-tagged FIFO and flush.
// Define PREFETCH_PERF_EN to add the saturating perf_discard_o / perf_starve_o counters.
module inst_prefetch #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  input  logic        inst_ready_i
`ifdef PREFETCH_PERF_EN
  ,
  output logic [31:0] perf_discard_o,
  output logic [31:0] perf_starve_o
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SW  = ((CW > OW) ? CW : OW) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t fifo_mem [DEPTH];

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [OW-1:0] out_q, out_d;
  logic [OW-1:0] discard_q, discard_d;
  logic [31:0] last_pc_q;

  logic [SW-1:0] inflight_sum;
  logic          empty, gnt_ok, rsp_ok, drop, push, pop;
  logic [31:0]   target_pc;
  logic          unused_pc_lsb;
  entry_t        head;

  assign unused_pc_lsb = ^flush_pc_i[1:0];
  assign target_pc     = {flush_pc_i[31:2], 2'b00};

  // A slot is reserved per granted read, so count + outstanding bounds FIFO occupancy.
  assign inflight_sum = SW'(count_q) + SW'(out_q);
  assign mem_req_o    = rst && !flush_i && (inflight_sum < SW'(DEPTH))
                        && (out_q < OW'(MAX_OUTSTANDING));
  assign mem_addr_o   = fetch_pc_q;

  assign gnt_ok = mem_req_o && mem_gnt_i;
  assign rsp_ok = mem_rvalid_i && (out_q != '0);
  assign drop   = rsp_ok && (flush_i || (discard_q != '0));
  assign push   = rsp_ok && !drop;

  assign empty        = (count_q == '0);
  assign head         = fifo_mem[rd_ptr_q];
  assign inst_valid_o = !empty;
  assign inst_o       = empty ? NOP : head.inst;
  assign pc_o         = empty ? last_pc_q : head.pc;
  assign pop          = inst_valid_o && inst_ready_i && !flush_i;

  // NOTE: every variable gets a default before the branches, so no latch is inferred.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    out_d      = out_q + OW'(gnt_ok) - OW'(rsp_ok);
    discard_d  = discard_q;
    if (flush_i) begin
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      discard_d  = out_q - OW'(rsp_ok);
    end else begin
      if (gnt_ok) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_ok && (discard_q != '0)) discard_d = discard_q - OW'(1);
      if (push) begin
        wr_ptr_d  = wr_ptr_q + PW'(1);
        resp_pc_d = resp_pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      out_q      <= '0;
      discard_q  <= '0;
      last_pc_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      out_q      <= out_d;
      discard_q  <= discard_d;
      last_pc_q  <= pc_o;
    end
  end

  // NOTE: FIFO storage is not reset; count_q gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= '{pc: resp_pc_q, inst: mem_rdata_i};
  end

`ifdef PREFETCH_PERF_EN
  logic [31:0] perf_discard_q, perf_starve_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_discard_q <= '0;
      perf_starve_q  <= '0;
    end else begin
      if (drop && (perf_discard_q != '1)) perf_discard_q <= perf_discard_q + 32'd1;
      if (inst_ready_i && !inst_valid_o && (perf_starve_q != '1))
        perf_starve_q <= perf_starve_q + 32'd1;
    end
  end

  assign perf_discard_o = perf_discard_q;
  assign perf_starve_o  = perf_starve_q;
`endif

endmodule

// File: tb/tb_inst_prefetch.sv
// Randomized bench for inst_prefetch: a bus stub with wait states and a queue-based reference model.
module tb_inst_prefetch;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_ready_i;
`ifdef PREFETCH_PERF_EN
  logic [31:0] perf_discard_o;
  logic [31:0] perf_starve_o;
`endif

  inst_prefetch #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .flush_pc_i   (flush_pc_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .pc_o         (pc_o),
    .inst_ready_i (inst_ready_i)
`ifdef PREFETCH_PERF_EN
    ,
    .perf_discard_o (perf_discard_o),
    .perf_starve_o  (perf_starve_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int unsigned due; } bus_t;
  typedef struct { logic [31:0] addr; bit stale; } infl_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

  bus_t  bus_q[$];
  infl_t m_infl[$];
  ent_t  m_fifo[$];
  logic [31:0] m_fetch, m_last_pc, m_perf_disc, m_perf_starve;

  int unsigned cyc;
  int gnt_pct, rdy_pct, rv_pct, max_lat;
  int total = 0;
  int bad   = 0;

  bit          s_req, s_valid, s_gnt;
  logic [31:0] s_addr, s_pc, s_inst;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ a[31:16], ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic set_knobs(input int g, input int r, input int v, input int l);
    gnt_pct = g; rdy_pct = r; rv_pct = v; max_lat = l;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; flush_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; inst_ready_i = 1'b0;
    #1;
    check("rst_req",   {31'b0, mem_req_o},    32'h0);
    check("rst_addr",  mem_addr_o,            32'h0);
    check("rst_valid", {31'b0, inst_valid_o}, 32'h0);
    check("rst_inst",  inst_o,                NOP);
    check("rst_pc",    pc_o,                  32'h0);
`ifdef PREFETCH_PERF_EN
    check("rst_perf_discard", perf_discard_o, 32'h0);
    check("rst_perf_starve",  perf_starve_o,  32'h0);
`endif
    bus_q.delete(); m_infl.delete(); m_fifo.delete();
    m_fetch = 32'h0; m_last_pc = 32'h0; m_perf_disc = 32'h0; m_perf_starve = 32'h0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One clock: drive inputs, compare outputs with the model, then advance bus stub and model.
  task automatic cycle(input bit fl, input logic [31:0] fpc);
    bit g, r, v, exp_req, exp_valid;
    logic [31:0] exp_inst, exp_pc;
    infl_t it;
    @(negedge clk);
    g = ($urandom_range(99) < gnt_pct);
    r = ($urandom_range(99) < rdy_pct);
    v = 1'b0;
    mem_rdata_i = $urandom();
    if (bus_q.size() != 0 && bus_q[0].due <= cyc && $urandom_range(99) < rv_pct) begin
      v = 1'b1;
      mem_rdata_i = mem_word(bus_q[0].addr);
    end
    flush_i = fl; flush_pc_i = fpc; mem_gnt_i = g; mem_rvalid_i = v; inst_ready_i = r;
    #1;
    exp_req   = !fl && (m_fifo.size() + m_infl.size() < DEPTH) && (m_infl.size() < MAXO);
    exp_valid = (m_fifo.size() != 0);
    exp_inst  = exp_valid ? m_fifo[0].inst : NOP;
    exp_pc    = exp_valid ? m_fifo[0].pc : m_last_pc;
    check("mem_req",    {31'b0, mem_req_o},    {31'b0, exp_req});
    check("mem_addr",   mem_addr_o,            m_fetch);
    check("inst_valid", {31'b0, inst_valid_o}, {31'b0, exp_valid});
    check("inst",       inst_o,                exp_inst);
    check("pc",         pc_o,                  exp_pc);
`ifdef PREFETCH_PERF_EN
    check("perf_discard", perf_discard_o, m_perf_disc);
    check("perf_starve",  perf_starve_o,  m_perf_starve);
`endif
    s_req = mem_req_o; s_addr = mem_addr_o; s_valid = inst_valid_o; s_pc = pc_o; s_inst = inst_o;
    s_gnt = mem_req_o && g;
    if (v) bus_q.delete(0);
    if (s_gnt) bus_q.push_back('{addr: mem_addr_o, due: cyc + 1 + $urandom_range(max_lat)});
    if (r && !exp_valid) m_perf_starve++;
    if (fl) begin
      if (v && m_infl.size() != 0) begin
        m_infl.delete(0);
        m_perf_disc++;
      end
      foreach (m_infl[i]) m_infl[i].stale = 1'b1;
      m_fifo.delete();
      m_fetch = {fpc[31:2], 2'b00};
    end else begin
      if (exp_valid && r) m_fifo.delete(0);
      if (v && m_infl.size() != 0) begin
        it = m_infl[0];
        m_infl.delete(0);
        if (it.stale) m_perf_disc++;
        else m_fifo.push_back('{pc: it.addr, inst: mem_word(it.addr)});
      end
      if (exp_req && g) begin
        m_infl.push_back('{addr: m_fetch, stale: 1'b0});
        m_fetch = m_fetch + 32'd4;
      end
    end
    m_last_pc = exp_pc;
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int grants;
    bit seen;
    bit fl_next;
    logic [31:0] first_addr;
    rst = 1'b0; flush_i = 1'b0; flush_pc_i = '0; mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0; mem_rdata_i = '0; inst_ready_i = 1'b0;
    cyc = 0;

    // Streaming: one instruction per cycle, first valid two cycles after the first grant.
    set_knobs(100, 100, 100, 0);
    do_reset();
    cycle(1'b0, '0); check("s1_addr0", s_addr, 32'h0);
    cycle(1'b0, '0); check("s1_addr1", s_addr, 32'h4);
    cycle(1'b0, '0); check("s1_first_pc", s_pc, 32'h0); check("s1_first_inst", s_inst, 32'h0000_FFFF);
    check("s1_first_valid", {31'b0, s_valid}, 32'h1);
    cycle(1'b0, '0); check("s1_second_pc", s_pc, 32'h4); check("s1_second_inst", s_inst, 32'h0004_FFFB);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0);

    // Back-pressure: exactly DEPTH grants, then drain in order and resume at 0x10.
    set_knobs(100, 0, 100, 0);
    do_reset();
    grants = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, '0);
      if (s_gnt) grants++;
    end
    check("s2_grants", grants, 4);
    check("s2_req_stalled", {31'b0, s_req}, 32'h0);
    set_knobs(100, 100, 100, 0);
    seen = 1'b0; first_addr = '0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0);
      check("s2_drain_pc", s_pc, 32'(i * 4));
      if (s_req && !seen) begin seen = 1'b1; first_addr = s_addr; end
    end
    check("s2_resume_addr", first_addr, 32'h10);

    // Wait states: address held while ungranted, advances after the grant.
    set_knobs(0, 100, 100, 0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0);
      check("s3_held_addr", s_addr, 32'h0);
    end
    set_knobs(100, 100, 100, 0);
    cycle(1'b0, '0); check("s3_gnt_addr", s_addr, 32'h0);
    cycle(1'b0, '0); check("s3_next_addr", s_addr, 32'h4);

    // Flush with two reads outstanding: both responses dropped, stream restarts at 0x100.
    set_knobs(100, 100, 0, 0);
    do_reset();
    cycle(1'b0, '0);
    cycle(1'b0, '0);
    cycle(1'b1, 32'h100);
    set_knobs(100, 100, 100, 0);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      cycle(1'b0, '0);
      if (s_valid) begin
        seen = 1'b1;
        check("s4_first_pc", s_pc, 32'h100);
        check("s4_first_inst", s_inst, 32'h0100_FEFF);
      end
    end
    check("s4_valid_seen", {31'b0, seen}, 32'h1);
`ifdef PREFETCH_PERF_EN
    check("s4_perf_discard", perf_discard_o, 32'h2);
`endif

    // Flush coinciding with rvalid and pop; unaligned target.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, '0);
    cycle(1'b1, 32'h203);
    cycle(1'b0, '0);
    check("s5_valid_cleared", {31'b0, s_valid}, 32'h0);
    check("s5_req", {31'b0, s_req}, 32'h1);
    check("s5_aligned_addr", s_addr, 32'h200);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      cycle(1'b0, '0);
      if (s_valid) begin seen = 1'b1; check("s5_first_pc", s_pc, 32'h200); end
    end
    check("s5_valid_seen", {31'b0, seen}, 32'h1);

    // Random phases: varied grant, ready and latency mixes with sporadic (sometimes back-to-back) flushes.
    fl_next = 1'b0;
    for (int p = 0; p < 6; p++) begin
      set_knobs((p % 3 == 0) ? 100 : ((p % 3 == 1) ? 70 : 30),
                (p < 2) ? 100 : ((p < 4) ? 50 : 10),
                (p % 2 == 0) ? 100 : 60,
                p % 4);
      for (int i = 0; i < 500; i++) begin
        bit fl;
        logic [31:0] fpc;
        fl = fl_next || ($urandom_range(99) < 3);
        fl_next = fl && ($urandom_range(99) < 30);
        fpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom();
        cycle(fl, fpc);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
